// File: rtl/h_hdr.sv
// Packet-header extraction stage: strips a fixed-length header, publishes length/tag,
// and forwards exactly `length` body beats with regenerated framing.
module h_hdr #(
  parameter int W         = 32,
  parameter int HDR_BEATS = 2,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [W-1:0]     in_dat,
  output logic             in_rdy,
  output logic             hdr_vld,
  output logic [LEN_W-1:0] hdr_len,
  output logic [7:0]       hdr_tag,
  output logic             out_vld,
  output logic             out_sop,
  output logic             out_eop,
  output logic [W-1:0]     out_dat,
  input  logic             out_rdy,
  output logic             err_vld,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DRAIN} state_t;

  localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(HDR_BEATS - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             accept;
  logic             last_hdr;
  logic [LEN_W-1:0] cur_len;

  // Only the body path is throttled by the single-entry output register.
  assign in_rdy = ~arst & ((state != BODY) | ~out_vld | out_rdy);
  assign accept = in_vld & in_rdy;

  // With a one-beat header the sop beat is also the last header beat, so its
  // length must come straight from the input rather than the latched copy.
  always_comb begin
    last_hdr = 1'b0;
    cur_len  = hdr_len;
    if (state == IDLE) begin
      cur_len  = in_dat[LEN_W-1:0];
      last_hdr = in_sop && (HDR_BEATS == 1);
    end else if (state == HDR) begin
      last_hdr = (cnt == HDR_LAST);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      cnt      <= '0;
      hdr_vld  <= 1'b0;
      hdr_len  <= '0;
      hdr_tag  <= '0;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_dat  <= '0;
      err_vld  <= 1'b0;
      err_code <= 2'd0;
    end else begin
      hdr_vld <= 1'b0;
      err_vld <= 1'b0;
      if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end

      if (accept) begin
        if (last_hdr) begin
          hdr_vld <= 1'b1;
          if (state == IDLE) begin
            hdr_len <= in_dat[LEN_W-1:0];
            hdr_tag <= in_dat[W-1:W-8];
          end
          cnt <= '0;
          if (cur_len == '0) begin
            if (in_eop) begin
              state <= IDLE;
            end else begin
              err_vld  <= 1'b1;
              err_code <= 2'd3;
              state    <= DRAIN;
            end
          end else if (in_eop) begin
            err_vld  <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else begin
            state <= BODY;
          end
        end else begin
          case (state)
            IDLE: begin
              if (in_sop) begin
                hdr_len <= in_dat[LEN_W-1:0];
                hdr_tag <= in_dat[W-1:W-8];
                cnt     <= ONE;
                if (in_eop) begin
                  err_vld  <= 1'b1;
                  err_code <= 2'd2;
                end else begin
                  state <= HDR;
                end
              end else begin
                err_vld  <= 1'b1;
                err_code <= 2'd1;
              end
            end

            HDR: begin
              if (in_eop) begin
                err_vld  <= 1'b1;
                err_code <= 2'd2;
                state    <= IDLE;
              end else begin
                cnt <= cnt + ONE;
              end
            end

            BODY: begin
              out_vld <= 1'b1;
              out_dat <= in_dat;
              out_sop <= (cnt == '0);
              cnt     <= cnt + ONE;
              // Exit on len-1 so the counter never has to represent len itself.
              if (cnt == hdr_len - ONE) begin
                out_eop <= 1'b1;
                if (in_eop) begin
                  state <= IDLE;
                end else begin
                  err_vld  <= 1'b1;
                  err_code <= 2'd3;
                  state    <= DRAIN;
                end
              end else if (in_eop) begin
                out_eop  <= 1'b1;
                err_vld  <= 1'b1;
                err_code <= 2'd2;
                state    <= IDLE;
              end else begin
                out_eop <= 1'b0;
              end
            end

            DRAIN: begin
              if (in_eop) begin
                state <= IDLE;
              end
            end

            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_h_hdr.sv
// Randomized packet-level bench for h_hdr: each packet's expected header, body beats
// and error code are derived from its shape and compared against the DUT's outputs.
module tb_h_hdr;

  localparam int W         = 32;
  localparam int HDR_BEATS = 2;
  localparam int LEN_W     = 16;

  localparam int K_NORMAL  = 0;
  localparam int K_SHORT   = 1;
  localparam int K_LONG    = 2;
  localparam int K_HDR_EOP = 3;
  localparam int K_TRUNC   = 4;
  localparam int K_STRAY   = 5;

  typedef struct packed {
    logic [W-1:0] dat;
    logic         sop;
    logic         eop;
    logic         body;
  } beat_t;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             in_vld = 1'b0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic [W-1:0]     in_dat = '0;
  logic             in_rdy;
  logic             hdr_vld;
  logic [LEN_W-1:0] hdr_len;
  logic [7:0]       hdr_tag;
  logic             out_vld;
  logic             out_sop;
  logic             out_eop;
  logic [W-1:0]     out_dat;
  logic             out_rdy = 1'b1;
  logic             err_vld;
  logic [1:0]       err_code;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int gap_pct = 0;
  bit ignore_mon = 1'b0;
  bit offering_body = 1'b0;

  logic [LEN_W+7:0] exp_hdr[$];
  logic [W+1:0]     exp_out[$];
  logic [1:0]       exp_err[$];

  h_hdr #(.W(W), .HDR_BEATS(HDR_BEATS), .LEN_W(LEN_W)) dut (
    .clk(clk), .arst(arst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_dat(in_dat), .in_rdy(in_rdy),
    .hdr_vld(hdr_vld), .hdr_len(hdr_len), .hdr_tag(hdr_tag),
    .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop), .out_dat(out_dat), .out_rdy(out_rdy),
    .err_vld(err_vld), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Downstream ready: always on, random, or the repeating 1,0,0 pattern.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ($urandom_range(0, 99) < 65);
        default: begin
          out_rdy = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  // Output monitor: pulses and body transfers are matched in order against the expectation queues.
  initial begin
    bit           prev_stall = 1'b0;
    logic [W+2:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (arst || ignore_mon) begin
        prev_stall = 1'b0;
      end else begin
        if (hdr_vld) begin
          if (exp_hdr.size() == 0) checkOutput("hdr_unexpected", 64'(hdr_len), 64'hDEAD);
          else checkOutput("hdr", 64'({hdr_tag, hdr_len}), 64'(exp_hdr.pop_front()));
        end
        if (err_vld) begin
          if (exp_err.size() == 0) checkOutput("err_unexpected", 64'(err_code), 64'd0);
          else checkOutput("err_code", 64'(err_code), 64'(exp_err.pop_front()));
        end
        if (prev_stall)
          checkOutput("out_hold", 64'({out_vld, out_sop, out_eop, out_dat}), 64'(prev_word));
        if (out_vld && out_rdy) begin
          if (exp_out.size() == 0) checkOutput("out_unexpected", 64'(out_dat), 64'hDEAD);
          else checkOutput("out_beat", 64'({out_sop, out_eop, out_dat}), 64'(exp_out.pop_front()));
        end
        prev_stall = out_vld && !out_rdy;
        prev_word  = {out_vld, out_sop, out_eop, out_dat};
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offers one beat and waits for the handshake; in_rdy is checked while waiting.
  task automatic applyStimulus(input beat_t b);
    int  waited = 0;
    bit  acc = 1'b0;
    in_vld = 1'b1;
    in_dat = b.dat;
    in_sop = b.sop;
    in_eop = b.eop;
    offering_body = b.body;
    do begin
      @(negedge clk);
      acc = in_rdy;
      if (b.body) checkOutput("in_rdy_body", 64'(in_rdy), 64'(!(out_vld && !out_rdy)));
      else        checkOutput("in_rdy_ctrl", 64'(in_rdy), 64'd1);
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_vld = 1'b0;
    offering_body = 1'b0;
    if ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic beat_t mkBeat(input logic eop, input logic body);
    beat_t b;
    b.dat  = W'($urandom);
    b.sop  = 1'($urandom);
    b.eop  = eop;
    b.body = body;
    return b;
  endfunction

  // Builds a packet of the given shape, queues what the DUT should produce, then drives it.
  task automatic sendPacket(input int kind, input int len, input int extra, input logic [7:0] tag);
    beat_t q[$];
    beat_t b;
    for (int i = 0; i < HDR_BEATS; i++) begin
      b = mkBeat(1'b0, 1'b0);
      if (i == 0) begin
        b.dat = {tag, (W-8-LEN_W)'($urandom), LEN_W'(len)};
        b.sop = 1'b1;
      end
      q.push_back(b);
    end
    case (kind)
      K_STRAY: begin
        q.delete();
        b = mkBeat(1'($urandom), 1'b0);
        b.sop = 1'b0;
        q.push_back(b);
        exp_err.push_back(2'd1);
      end
      K_TRUNC: begin
        while (q.size() > extra + 1) void'(q.pop_back());
        b = q.pop_back();
        b.eop = 1'b1;
        q.push_back(b);
        exp_err.push_back(2'd2);
      end
      K_HDR_EOP: begin
        b = q.pop_back();
        b.eop = 1'b1;
        q.push_back(b);
        exp_hdr.push_back({tag, LEN_W'(len)});
        exp_err.push_back(2'd2);
      end
      K_NORMAL: begin
        exp_hdr.push_back({tag, LEN_W'(len)});
        if (len == 0) begin
          b = q.pop_back();
          b.eop = 1'b1;
          q.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
          b = mkBeat(i == len - 1, 1'b1);
          q.push_back(b);
          exp_out.push_back({i == 0, i == len - 1, b.dat});
        end
      end
      K_SHORT: begin
        exp_hdr.push_back({tag, LEN_W'(len)});
        for (int i = 0; i < extra; i++) begin
          b = mkBeat(i == extra - 1, 1'b1);
          q.push_back(b);
          exp_out.push_back({i == 0, i == extra - 1, b.dat});
        end
        exp_err.push_back(2'd2);
      end
      default: begin
        exp_hdr.push_back({tag, LEN_W'(len)});
        for (int i = 0; i < len; i++) begin
          b = mkBeat(1'b0, 1'b1);
          q.push_back(b);
          exp_out.push_back({i == 0, i == len - 1, b.dat});
        end
        for (int i = 0; i < extra; i++) q.push_back(mkBeat(i == extra - 1, 1'b0));
        exp_err.push_back(2'd3);
      end
    endcase
    foreach (q[i]) applyStimulus(q[i]);
  endtask

  task automatic settle(input int cycles);
    int saved = rdy_mode;
    rdy_mode = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rdy_mode = saved;
  endtask

  task automatic checkReset(input string tag);
    @(negedge clk);
    checkOutput({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
    checkOutput({tag, "_out"}, 64'({out_vld, out_sop, out_eop, out_dat}), 64'd0);
    checkOutput({tag, "_hdr"}, 64'({hdr_vld, hdr_tag, hdr_len}), 64'd0);
    checkOutput({tag, "_err"}, 64'({err_vld, err_code}), 64'd0);
  endtask

  initial begin
    beat_t b;
    int kind, len, extra;
    checkReset("reset");
    @(posedge clk);
    #1;
    arst = 1'b0;
    @(posedge clk);
    #1;

    sendPacket(K_NORMAL, 3, 0, 8'hA5);
    sendPacket(K_NORMAL, 3, 0, 8'hA5);
    sendPacket(K_NORMAL, 0, 0, 8'h3C);
    sendPacket(K_SHORT, 4, 2, 8'h11);
    sendPacket(K_NORMAL, 1, 0, 8'h22);
    sendPacket(K_LONG, 2, 3, 8'h33);
    rdy_mode = 2;
    sendPacket(K_NORMAL, 4, 0, 8'h44);
    settle(10);

    // Reset in the middle of a body: nothing from this packet may surface.
    ignore_mon = 1'b1;
    b = mkBeat(1'b0, 1'b0);
    b.sop = 1'b1;
    b.dat = {8'h55, 8'h00, LEN_W'(5)};
    applyStimulus(b);
    for (int i = 1; i < HDR_BEATS; i++) applyStimulus(mkBeat(1'b0, 1'b0));
    applyStimulus(mkBeat(1'b0, 1'b1));
    applyStimulus(mkBeat(1'b0, 1'b1));
    arst = 1'b1;
    checkReset("midreset");
    @(posedge clk);
    #1;
    arst = 1'b0;
    exp_hdr.delete();
    exp_out.delete();
    exp_err.delete();
    ignore_mon = 1'b0;
    sendPacket(K_STRAY, 0, 0, 8'h00);
    sendPacket(K_NORMAL, 2, 0, 8'h66);

    sendPacket(K_LONG, 0, 2, 8'h77);
    sendPacket(K_TRUNC, 0, 0, 8'h88);
    sendPacket(K_HDR_EOP, 3, 0, 8'h99);
    sendPacket(K_NORMAL, 2, 0, 8'hAA);

    rdy_mode = 1;
    gap_pct = 20;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        K_SHORT:   begin len = $urandom_range(2, 6); extra = $urandom_range(1, len - 1); end
        K_LONG:    begin len = $urandom_range(0, 5); extra = $urandom_range(1, 3); end
        K_HDR_EOP: begin len = $urandom_range(1, 6); extra = 0; end
        K_TRUNC:   begin len = $urandom_range(0, 6); extra = $urandom_range(0, HDR_BEATS - 2); end
        default:   begin len = $urandom_range(0, 6); extra = 0; end
      endcase
      sendPacket(kind, len, extra, 8'($urandom));
    end

    settle(20);
    checkOutput("left_hdr", 64'(exp_hdr.size()), 64'd0);
    checkOutput("left_out", 64'(exp_out.size()), 64'd0);
    checkOutput("left_err", 64'(exp_err.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
